// File: rtl/scroll_controller.sv
// Frame-synchronous scroll sequencer: ramps move/halt requests into a per-frame speed and advances fine/coarse scroll position.
// All outputs update on the first blanking-line tick (x==0, y==FRAME_Y) and are held for the whole following frame; no backpressure.
module scroll_controller #(
  parameter int unsigned FRAME_Y     = 480,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned RAMP_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       move,
  input  logic       halt,
  output logic [9:0] offset_ARM,
  output logic [7:0] tile_col,
  output logic [2:0] speed,
  output logic       scrolling,
  output logic       frame_tick,
  output logic [15:0] distance
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BRAKE = 2'd2;

  localparam logic [2:0] MAX_SP   = 3'(MAX_SPEED);
  localparam logic [7:0] RAMP_END = 8'(RAMP_FRAMES - 1);
  localparam logic [9:0] TICK_Y   = 10'(FRAME_Y);

  logic [1:0]  state_q, state_d;
  logic [2:0]  speed_q, speed_d;
  logic [4:0]  offset_q, offset_d;
  logic [7:0]  tile_col_q, tile_col_d;
  logic [15:0] distance_q, distance_d;
  logic [7:0]  ramp_cnt_q, ramp_cnt_d;
  logic        scrolling_q, scrolling_d;
  logic        frame_tick_q, frame_tick_d;

  logic        tick_c;
  logic        ramp_last;
  logic [5:0]  sum;
  logic [16:0] dist_sum;

  assign tick_c    = (x == 10'd0) && (y == TICK_Y);
  assign ramp_last = (ramp_cnt_q == RAMP_END);
  assign sum       = {1'b0, offset_q} + {3'b000, speed_q};
  assign dist_sum  = {1'b0, distance_q} + {14'd0, speed_q};

  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    offset_d     = offset_q;
    tile_col_d   = tile_col_q;
    distance_d   = distance_q;
    ramp_cnt_d   = ramp_cnt_q;
    frame_tick_d = tick_c;

    if (tick_c) begin
      // Advance with the speed held before this tick; sum < 64 so sum[4:0] is sum-32 on carry.
      offset_d   = sum[4:0];
      tile_col_d = sum[5] ? tile_col_q + 8'd1 : tile_col_q;
      distance_d = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];

      case (state_q)
        S_IDLE: begin
          if (move && !halt) begin
            state_d    = S_RUN;
            speed_d    = 3'd1;
            ramp_cnt_d = 8'd0;
          end
        end
        S_RUN: begin
          if (halt) begin
            state_d = S_IDLE;
            speed_d = 3'd0;
          end else if (!move) begin
            state_d    = S_BRAKE;
            ramp_cnt_d = 8'd0;
          end else if (ramp_last) begin
            speed_d    = (speed_q >= MAX_SP) ? MAX_SP : speed_q + 3'd1;
            ramp_cnt_d = 8'd0;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 8'd1;
          end
        end
        S_BRAKE: begin
          if (halt) begin
            state_d = S_IDLE;
            speed_d = 3'd0;
          end else if (move) begin
            state_d    = S_RUN;
            ramp_cnt_d = 8'd0;
          end else if (ramp_last) begin
            speed_d    = speed_q - 3'd1;
            ramp_cnt_d = 8'd0;
            if (speed_q == 3'd1) state_d = S_IDLE;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          speed_d = 3'd0;
        end
      endcase
    end

    scrolling_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      speed_q      <= 3'd0;
      offset_q     <= 5'd0;
      tile_col_q   <= 8'd0;
      distance_q   <= 16'd0;
      ramp_cnt_q   <= 8'd0;
      scrolling_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      offset_q     <= offset_d;
      tile_col_q   <= tile_col_d;
      distance_q   <= distance_d;
      ramp_cnt_q   <= ramp_cnt_d;
      scrolling_q  <= scrolling_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign offset_ARM = {5'd0, offset_q};
  assign tile_col   = tile_col_q;
  assign speed      = speed_q;
  assign scrolling  = scrolling_q;
  assign frame_tick = frame_tick_q;
  assign distance   = distance_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Randomized bench for scroll_controller against a position-based reference model.
module tb_scroll_controller;
  localparam int FY   = 480;
  localparam int MAXS = 4;
  localparam int RAMP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        move, halt;
  logic [9:0]  offset_ARM;
  logic [7:0]  tile_col;
  logic [2:0]  speed;
  logic        scrolling;
  logic        frame_tick;
  logic [15:0] distance;

  scroll_controller #(.FRAME_Y(FY), .MAX_SPEED(MAXS), .RAMP_FRAMES(RAMP)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .move(move), .halt(halt),
    .offset_ARM(offset_ARM), .tile_col(tile_col), .speed(speed),
    .scrolling(scrolling), .frame_tick(frame_tick), .distance(distance)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  // Reference model: absolute pixel position plus a mode (0 idle, 1 run, 2 brake).
  longint m_pos;
  int     m_mode, m_spd, m_cnt;

  logic [37:0] obs;
  assign obs = {offset_ARM, tile_col, speed, scrolling, distance};

  function automatic logic [37:0] exp_vec();
    logic [15:0] d;
    d = (m_pos > 65535) ? 16'hFFFF : 16'(m_pos);
    return {10'(m_pos % 32), 8'((m_pos / 32) % 256), 3'(m_spd), (m_mode != 0), d};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_spd = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic mv, input logic ht);
    m_pos += m_spd;
    case (m_mode)
      0: if (mv && !ht) begin m_mode = 1; m_spd = 1; m_cnt = 0; end
      1: begin
        if (ht) begin m_mode = 0; m_spd = 0; end
        else if (!mv) begin m_mode = 2; m_cnt = 0; end
        else if (m_cnt == RAMP - 1) begin m_spd = (m_spd + 1 > MAXS) ? MAXS : m_spd + 1; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        if (ht) begin m_mode = 0; m_spd = 0; end
        else if (mv) begin m_mode = 1; m_cnt = 0; end
        else if (m_cnt == RAMP - 1) begin m_spd--; m_cnt = 0; if (m_spd == 0) m_mode = 0; end
        else m_cnt++;
      end
    endcase
  endtask

  task automatic rand_xy();
    x = 10'($urandom_range(0, 799));
    y = 10'($urandom_range(0, 524));
    if (x == 10'd0 && y == 10'(FY)) x = 10'd1;
  endtask

  // Random non-tick cycles, then one tick cycle; returns at the negedge after the tick edge.
  task automatic tick(input logic mv, input logic ht, input int gap);
    repeat (gap) begin
      @(negedge clk);
      move = 1'($urandom); halt = 1'($urandom); rand_xy();
    end
    @(negedge clk);
    move = mv; halt = ht; x = 10'd0; y = 10'(FY);
    @(negedge clk);
    x = 10'd7; y = 10'd3;
    model_step(mv, ht);
  endtask

  task automatic test_reset();
    rst = 1'b1; move = 1'b0; halt = 1'b0; x = 10'd5; y = 10'd5;
    model_reset();
    #2;
    vec++;
    if ({obs, frame_tick} !== 39'd0) begin err++; $display("FAIL reset_init: got %h want 0", {obs, frame_tick}); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick(1'b1, 1'b0, $urandom_range(0, 3));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL reset_rampup: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
    end
    vec++;
    if (speed !== 3'd3) begin err++; $display("FAIL reset_pre_speed: got %0d want 3", speed); end
    @(negedge clk); move = 1'b0; rst = 1'b1;
    #1;
    vec++;
    if ({obs, frame_tick} !== 39'd0) begin err++; $display("FAIL reset_async: got %h want 0", {obs, frame_tick}); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    tick(1'b0, 1'b0, 2);
    vec++;
    if ({obs, frame_tick} !== {exp_vec(), 1'b1} || scrolling !== 1'b0) begin err++; $display("FAIL reset_idle_tick: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
    @(negedge clk);
    vec++;
    if (frame_tick !== 1'b0) begin err++; $display("FAIL reset_tick_pulse: got %b want 0", frame_tick); end
  endtask

  task automatic test_accel();
    int want;
    for (int k = 0; k <= 40; k++) begin
      tick(1'b1, 1'b0, $urandom_range(0, 3));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL accel_model k=%0d: got %h want %h", k, {obs, frame_tick}, {exp_vec(), 1'b1}); end
      if (k == 0 || k == 8 || k == 16 || k == 24 || k == 40) begin
        want = (k / 8 + 1 > 4) ? 4 : k / 8 + 1;
        vec++;
        if (speed !== 3'(want)) begin err++; $display("FAIL accel_speed k=%0d: got %0d want %0d", k, speed, want); end
      end
      if (k == 24) begin
        vec++;
        if (distance !== 16'd48) begin err++; $display("FAIL accel_distance: got %0d want 48", distance); end
      end
    end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    longint prev_tile;
    for (int k = 0; k < 2200 && !seen; k++) begin
      prev_tile = (m_pos / 32) % 256;
      tick(1'b1, 1'b0, 0);
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL wrap_model: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
      if (prev_tile == 255 && (m_pos / 32) % 256 == 0) begin
        seen = 1;
        vec++;
        if (tile_col !== 8'd0 || offset_ARM !== 10'(m_pos % 32)) begin err++; $display("FAIL wrap_point: got tile %0d off %0d want 0 %0d", tile_col, offset_ARM, m_pos % 32); end
      end
    end
    vec++;
    if (!seen) begin err++; $display("FAIL wrap_timeout: got no wrap want wrap within 2200 ticks"); end
  endtask

  task automatic test_brake();
    tick(1'b0, 1'b0, 1);
    vec++;
    if (speed !== 3'd4 || scrolling !== 1'b1) begin err++; $display("FAIL brake_entry: got spd %0d scr %b want 4 1", speed, scrolling); end
    for (int j = 1; j <= 16; j++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 2));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL brake_model j=%0d: got %h want %h", j, {obs, frame_tick}, {exp_vec(), 1'b1}); end
      if (j == 7 || j == 8 || j == 16) begin
        vec++;
        if (speed !== ((j == 7) ? 3'd4 : (j == 8) ? 3'd3 : 3'd2)) begin err++; $display("FAIL brake_speed j=%0d: got %0d", j, speed); end
      end
    end
    tick(1'b1, 1'b0, 1);
    vec++;
    if (speed !== 3'd2 || scrolling !== 1'b1) begin err++; $display("FAIL reverse_entry: got spd %0d scr %b want 2 1", speed, scrolling); end
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 1'b0, $urandom_range(0, 2));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL reverse_model j=%0d: got %h want %h", j, {obs, frame_tick}, {exp_vec(), 1'b1}); end
      if (j >= 7) begin
        vec++;
        if (speed !== ((j == 7) ? 3'd2 : 3'd3)) begin err++; $display("FAIL reverse_speed j=%0d: got %0d", j, speed); end
      end
    end
  endtask

  task automatic test_halt();
    logic [9:0] want_off;
    want_off = 10'((m_pos + 3) % 32);
    tick(1'b1, 1'b1, 1);
    vec++;
    if (offset_ARM !== want_off || speed !== 3'd0 || scrolling !== 1'b0) begin
      err++; $display("FAIL halt_prio: got off %0d spd %0d scr %b want %0d 0 0", offset_ARM, speed, scrolling, want_off);
    end
    for (int j = 0; j < 4; j++) begin
      tick(1'b1, 1'b1, $urandom_range(0, 3));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1} || offset_ARM !== want_off) begin err++; $display("FAIL halt_hold: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
    end
  endtask

  task automatic test_stability();
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b0, 1);
    halt = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b0}) begin err++; $display("FAIL stable_hold c=%0d: got %h want %h", c, {obs, frame_tick}, {exp_vec(), 1'b0}); end
      move = (c >= 50 && c < 150) ? 1'b0 : 1'b1;
      if (c < 100) begin x = 10'd0; y = 10'(c); end
      else if (c < 200) begin x = 10'(c); y = 10'(FY); end
      else rand_xy();
    end
    tick(1'b1, 1'b0, 0);
    vec++;
    if ({obs, frame_tick} !== {exp_vec(), 1'b1} || scrolling !== 1'b1) begin err++; $display("FAIL stable_after: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
  endtask

  task automatic test_random();
    logic mv, ht;
    for (int k = 0; k < 400; k++) begin
      mv = ($urandom_range(0, 9) < 7);
      ht = ($urandom_range(0, 19) == 0);
      tick(mv, ht, $urandom_range(0, 3));
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL random k=%0d: got %h want %h", k, {obs, frame_tick}, {exp_vec(), 1'b1}); end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20000 && m_pos < 65545; k++) begin
      tick(1'b1, 1'b0, 0);
      vec++;
      if ({obs, frame_tick} !== {exp_vec(), 1'b1}) begin err++; $display("FAIL saturate_model: got %h want %h", {obs, frame_tick}, {exp_vec(), 1'b1}); end
    end
    vec++;
    if (distance !== 16'hFFFF || m_pos < 65545) begin err++; $display("FAIL saturate_end: got %0d want 65535", distance); end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_wrap();
    test_brake();
    test_halt();
    test_stability();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/scroll_controller.md
# scroll_controller

Frame-synchronous scroll sequencer for the tiled ground row of the VGA game. It turns the game-logic `move`/`halt` requests into a ramped per-frame scroll speed. It drives the fine pixel offset (0–31) that feeds the block repeater's `offset_ARM` input, plus a coarse tile-column index for map lookup. All outputs change only on the first line of vertical blanking, so the visible frame never tears.

## Interface

Parameters:
- `FRAME_Y`, 480: scanline on which the frame tick fires (first blanking line).
- `MAX_SPEED`, 4: top scroll speed in px/frame; legal range 1–7.
- `RAMP_FRAMES`, 8: frames per speed step during acceleration and braking; legal range 1–255.

Ports:
- `clk`, in, 1: pixel clock, the same clock as the VGA counters.
- `rst`, in, 1: reset, asynchronous and active-high.
- `x`, in, 10: current pixel column from the VGA timing block.
- `y`, in, 10: current scanline from the VGA timing block.
- `move`, in, 1: level request to scroll forward.
- `halt`, in, 1: level request for an immediate stop (collision); overrides `move`.
- `offset_ARM`, out, 10: fine scroll offset; values 0–31 only; bits [9:5] are always 0.
- `tile_col`, out, 8: coarse map column; wraps mod 256.
- `speed`, out, 3: current px/frame.
- `scrolling`, out, 1: high whenever state ≠ IDLE.
- `frame_tick`, out, 1: one-cycle registered pulse, one per frame.
- `distance`, out, 16: total pixels scrolled; saturates at 65535.

## Operation

- Tick condition `tick_c` is `x==0 && y==FRAME_Y`, sampled on the rising `clk` edge. All state, speed, offset and counter updates happen only on that edge. `frame_tick` is high during the following cycle.
- Order within one tick:
  1. Advance position using the speed held before the tick.
  2. Update state and speed.
- Position advance: `sum = offset_ARM + speed`, computed 6 bits wide.
  - If `sum >= 32`: `offset_ARM <= sum-32` and `tile_col <= tile_col+1`. At most one carry per tick, because speed ≤ 7.
  - Otherwise: `offset_ARM <= sum`.
  - `distance <= min(distance+speed, 65535)`.
- FSM states: IDLE, RUN, BRAKE. An 8-bit `ramp_cnt` counts ticks within RUN and BRAKE.
- IDLE (speed 0):
  - `move && !halt` → RUN, speed 1, `ramp_cnt` 0.
  - Otherwise stay.
- RUN:
  - `halt` → IDLE, speed 0.
  - `!move` → BRAKE, `ramp_cnt` 0, speed unchanged.
  - Otherwise, if `ramp_cnt == RAMP_FRAMES-1`: speed becomes min(speed+1, MAX_SPEED) and `ramp_cnt` 0. Else `ramp_cnt` +1.
- BRAKE:
  - `halt` → IDLE, speed 0.
  - `move` → RUN, `ramp_cnt` 0, speed unchanged.
  - Otherwise, if `ramp_cnt == RAMP_FRAMES-1`: speed −1 and `ramp_cnt` 0. When the new speed is 0, go to IDLE. Else `ramp_cnt` +1.
- Priority on a tick: `halt` > `move`. When both are asserted, the block behaves as halt.
- `halt` does not alter `offset_ARM`, `tile_col` or `distance` beyond the same-tick advance at the old speed.
- Inputs held between ticks are ignored. Only the value present at the tick edge matters; no latching of short pulses.

## Timing

- Reset values (asynchronous, applied immediately on `rst` high): `offset_ARM` 0, `tile_col` 0, `speed` 0, `scrolling` 0, `frame_tick` 0, `distance` 0, `ramp_cnt` 0, state IDLE.
- Reset mid-frame or mid-ramp discards all progress. The first tick after `rst` falls behaves as IDLE.
- Latency from `move` rising to the first pixel of scroll:
  - `move` is sampled at tick N; speed becomes 1 at tick N.
  - `offset_ARM` first changes at tick N+1.
- `speed`, `scrolling`, `offset_ARM` and `tile_col` are registered. They change on the tick edge and stay constant for the whole following frame.
- `frame_tick` fires exactly once per frame, whatever the state. If `y` never reaches `FRAME_Y`, there are no ticks and all outputs hold.
- `RAMP_FRAMES==1` is legal: speed steps every tick.

## Test plan

1. Reset mid-run: scroll to speed 3, assert `rst` between ticks → all outputs 0 on the same cycle, without waiting for a `clk` edge. After release, state is IDLE and `frame_tick` still pulses once per frame.
2. Acceleration, `RAMP_FRAMES`=8, `MAX_SPEED`=4: hold `move` from tick 0.
   - Required speed sequence: 1 at tick 0, 2 at tick 8, 3 at tick 16, 4 at tick 24, still 4 at tick 40.
   - `distance` at tick 24 is 8·1+8·2+8·3 = 48.
3. Wrap: force speed 4 with `offset_ARM`=30, `tile_col`=255 → next tick gives `offset_ARM`=2, `tile_col`=0.
4. Brake and reverse: from speed 4, drop `move` → speed 3, 2 at the 8th and 16th ticks after. Raise `move` at speed 2 → state RUN, speed 2, and the next increment comes 8 ticks later.
5. Halt priority: at speed 3, `offset_ARM`=10, assert `halt` and `move` together on a tick → `offset_ARM`=13, speed 0, `scrolling` 0, and the block stays IDLE while `halt` is held.
6. Stability: toggle `move` only between ticks, for example a 100-cycle pulse during the active area → no change to speed or offset, and no glitch on `offset_ARM` at any cycle with `y<480`.
